// File: rtl/ram_4port_arbiter.sv
// Round-robin arbiter sharing a 4-port RAM among NUM_REQ requesters; issues up to
// four hazard-free accesses per cycle and routes fixed-latency responses back by id.
module ram_4port_arbiter #(
    parameter int NUM_REQ       = 8,
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int READ_LATENCY  = 2,
    parameter int ID_WIDTH      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_val,
    output logic [NUM_REQ-1:0]               req_rdy,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ-1:0]               req_we,
    output logic [NUM_REQ-1:0]               resp_val,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    resp_data,
    output logic [ADDRESS_WIDTH-1:0]         port0_addr,
    output logic [DATA_WIDTH-1:0]            port0_write_data,
    output logic                             port0_en,
    output logic                             port0_we,
    input  logic [DATA_WIDTH-1:0]            port0_read_data,
    output logic [ADDRESS_WIDTH-1:0]         port1_addr,
    output logic [DATA_WIDTH-1:0]            port1_write_data,
    output logic                             port1_en,
    output logic                             port1_we,
    input  logic [DATA_WIDTH-1:0]            port1_read_data,
    output logic [ADDRESS_WIDTH-1:0]         port2_addr,
    output logic [DATA_WIDTH-1:0]            port2_write_data,
    output logic                             port2_en,
    output logic                             port2_we,
    input  logic [DATA_WIDTH-1:0]            port2_read_data,
    output logic [ADDRESS_WIDTH-1:0]         port3_addr,
    output logic [DATA_WIDTH-1:0]            port3_write_data,
    output logic                             port3_en,
    output logic                             port3_we,
    input  logic [DATA_WIDTH-1:0]            port3_read_data
);

    localparam int NUM_PORTS = 4;

    logic [ADDRESS_WIDTH-1:0] w_slot_addr [NUM_PORTS];
    logic [DATA_WIDTH-1:0]    w_slot_data [NUM_PORTS];
    logic [ID_WIDTH-1:0]      w_slot_id   [NUM_PORTS];
    logic [NUM_PORTS-1:0]     w_slot_en;
    logic [NUM_PORTS-1:0]     w_slot_we;
    logic [ID_WIDTH-1:0]      r_rr_ptr;
    logic [ID_WIDTH-1:0]      w_rr_next;

    logic [ADDRESS_WIDTH-1:0] w_port_addr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0]    w_port_wdata [NUM_PORTS];
    logic [NUM_PORTS-1:0]     w_port_en;
    logic [NUM_PORTS-1:0]     w_port_we;
    logic [DATA_WIDTH-1:0]    w_rdata      [NUM_PORTS];
    logic [NUM_PORTS-1:0]     w_out_val;
    logic [NUM_PORTS-1:0]     w_out_we;
    logic [ID_WIDTH-1:0]      w_out_id     [NUM_PORTS];

    // Scan from r_rr_ptr; a candidate colliding with an accepted slot (any write
    // involved) is skipped but does not end the scan.
    always_comb begin
        int                       cnt;
        int                       idx;
        logic                     hazard;
        logic [ADDRESS_WIDTH-1:0] a;
        logic                     wr;
        cnt       = 0;
        idx       = 0;
        hazard    = 1'b0;
        a         = '0;
        wr        = 1'b0;
        req_rdy   = '0;
        w_rr_next = r_rr_ptr;
        w_slot_en = '0;
        w_slot_we = '0;
        for (int s = 0; s < NUM_PORTS; s++) begin
            w_slot_addr[s] = '0;
            w_slot_data[s] = '0;
            w_slot_id[s]   = '0;
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = int'(r_rr_ptr) + j;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            a      = req_addr[idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            wr     = req_we[idx];
            hazard = 1'b0;
            for (int s = 0; s < NUM_PORTS; s++) begin
                if (s < cnt && w_slot_addr[s] == a && (w_slot_we[s] || wr)) hazard = 1'b1;
            end
            if (reset && req_val[idx] && cnt < NUM_PORTS && !hazard) begin
                for (int s = 0; s < NUM_PORTS; s++) begin
                    if (s == cnt) begin
                        w_slot_en[s]   = 1'b1;
                        w_slot_we[s]   = wr;
                        w_slot_addr[s] = a;
                        w_slot_data[s] = req_wdata[idx*DATA_WIDTH +: DATA_WIDTH];
                        w_slot_id[s]   = ID_WIDTH'(idx);
                    end
                end
                req_rdy[idx] = 1'b1;
                w_rr_next    = (idx == NUM_REQ - 1) ? '0 : ID_WIDTH'(idx + 1);
                cnt          = cnt + 1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rr_ptr <= '0;
        else        r_rr_ptr <= w_rr_next;
    end

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic                     r_en;
            logic                     r_we;
            logic [ADDRESS_WIDTH-1:0] r_addr;
            logic [DATA_WIDTH-1:0]    r_data;
            logic [READ_LATENCY:0]    r_pv;
            logic [READ_LATENCY:0]    r_pwe;
            logic [ID_WIDTH-1:0]      r_pid [READ_LATENCY+1];

            // Stage 0 loads alongside the issue register, so the tail stage lines
            // up with the RAM's read data.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_en   <= 1'b0;
                    r_we   <= 1'b0;
                    r_addr <= '0;
                    r_data <= '0;
                    r_pv   <= '0;
                    r_pwe  <= '0;
                    for (int s = 0; s <= READ_LATENCY; s++) r_pid[s] <= '0;
                end else begin
                    r_en <= w_slot_en[gi];
                    r_we <= w_slot_we[gi];
                    if (w_slot_en[gi]) begin
                        r_addr <= w_slot_addr[gi];
                        r_data <= w_slot_data[gi];
                    end
                    r_pv[0]  <= w_slot_en[gi];
                    r_pwe[0] <= w_slot_we[gi];
                    r_pid[0] <= w_slot_id[gi];
                    for (int s = 1; s <= READ_LATENCY; s++) begin
                        r_pv[s]  <= r_pv[s-1];
                        r_pwe[s] <= r_pwe[s-1];
                        r_pid[s] <= r_pid[s-1];
                    end
                end
            end

            assign w_port_en[gi]    = r_en;
            assign w_port_we[gi]    = r_we;
            assign w_port_addr[gi]  = r_addr;
            assign w_port_wdata[gi] = r_data;
            assign w_out_val[gi]    = r_pv[READ_LATENCY];
            assign w_out_we[gi]     = r_pwe[READ_LATENCY];
            assign w_out_id[gi]     = r_pid[READ_LATENCY];
        end
    endgenerate

    assign port0_addr       = w_port_addr[0];
    assign port0_write_data = w_port_wdata[0];
    assign port0_en         = w_port_en[0];
    assign port0_we         = w_port_we[0];
    assign port1_addr       = w_port_addr[1];
    assign port1_write_data = w_port_wdata[1];
    assign port1_en         = w_port_en[1];
    assign port1_we         = w_port_we[1];
    assign port2_addr       = w_port_addr[2];
    assign port2_write_data = w_port_wdata[2];
    assign port2_en         = w_port_en[2];
    assign port2_we         = w_port_we[2];
    assign port3_addr       = w_port_addr[3];
    assign port3_write_data = w_port_wdata[3];
    assign port3_en         = w_port_en[3];
    assign port3_we         = w_port_we[3];

    assign w_rdata[0] = port0_read_data;
    assign w_rdata[1] = port1_read_data;
    assign w_rdata[2] = port2_read_data;
    assign w_rdata[3] = port3_read_data;

    // One grant per requester per cycle means no two ports ever target the same id here.
    always_comb begin
        resp_val  = '0;
        resp_data = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (w_out_val[k]) begin
                resp_val[w_out_id[k]] = 1'b1;
                if (!w_out_we[k]) resp_data[int'(w_out_id[k])*DATA_WIDTH +: DATA_WIDTH] = w_rdata[k];
            end
        end
    end

endmodule
